score_bcd_counter: RTL and testbench

Game score keeper for the Flappy Bird datapath. It counts pipe-pass events from the game logic as three BCD digits and tracks a best score across games. It drives the `ge`/`shi`/`bai` digit inputs of the seven-segment scan driver, so the driver never needs a binary-to-BCD conversion. It also exports binary copies for the game/VGA logic.

---
 rtl/score_bcd_counter.sv | 158 +++++++++++++++
 tb/tb_score_bcd_counter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_counter.sv
// Game score keeper: three-digit BCD score with a binary shadow, and a best
// score kept across games. Feeds the seven-segment driver directly in BCD.
module score_bcd_counter #(
  parameter int unsigned MAX_SCORE = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pass,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       show_best,
  output logic [3:0] ge,
  output logic [3:0] shi,
  output logic [3:0] bai,
  output logic [9:0] score_bin,
  output logic [9:0] best_bin,
  output logic       running,
  output logic       saturated,
  output logic       new_best
);

  localparam int unsigned SCORE_W = 10;
  localparam int unsigned DIG_W   = 4;
  localparam logic [SCORE_W-1:0] MAX_BIN = SCORE_W'(MAX_SCORE);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               pass_q;
  logic [DIG_W-1:0]   cur_ge_q, cur_shi_q, cur_bai_q;
  logic [DIG_W-1:0]   cur_ge_d, cur_shi_d, cur_bai_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [DIG_W-1:0]   best_ge_q, best_shi_q, best_bai_q;
  logic [DIG_W-1:0]   best_ge_d, best_shi_d, best_bai_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic               running_q, running_d;
  logic               sat_q, sat_d;
  logic               new_best_q, new_best_d;

  logic               pass_rise;
  logic [DIG_W-1:0]   inc_ge, inc_shi, inc_bai;

  assign pass_rise = pass & ~pass_q;

  // BCD ripple increment of the current score digits
  always_comb begin
    inc_ge  = cur_ge_q + DIG_W'(1);
    inc_shi = cur_shi_q;
    inc_bai = cur_bai_q;
    if (cur_ge_q == DIG_W'(9)) begin
      inc_ge  = '0;
      inc_shi = cur_shi_q + DIG_W'(1);
      if (cur_shi_q == DIG_W'(9)) begin
        inc_shi = '0;
        inc_bai = cur_bai_q + DIG_W'(1);
      end
    end
  end

  // Next-state: game FSM, score update, best commit
  always_comb begin
    state_d    = state_q;
    cur_ge_d   = cur_ge_q;
    cur_shi_d  = cur_shi_q;
    cur_bai_d  = cur_bai_q;
    score_d    = score_q;
    best_ge_d  = best_ge_q;
    best_shi_d = best_shi_q;
    best_bai_d = best_bai_q;
    best_d     = best_q;
    new_best_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (game_start) begin
          state_d   = ST_RUN;
          cur_ge_d  = '0;
          cur_shi_d = '0;
          cur_bai_d = '0;
          score_d   = '0;
        end
      end
      ST_RUN: begin
        if (game_start) begin
          cur_ge_d  = '0;
          cur_shi_d = '0;
          cur_bai_d = '0;
          score_d   = '0;
        end else if (game_over) begin
          state_d = ST_OVER;
          if (score_q > best_q) begin
            best_ge_d  = cur_ge_q;
            best_shi_d = cur_shi_q;
            best_bai_d = cur_bai_q;
            best_d     = score_q;
            new_best_d = 1'b1;
          end
        end else if (pass_rise && (score_q != MAX_BIN)) begin
          cur_ge_d  = inc_ge;
          cur_shi_d = inc_shi;
          cur_bai_d = inc_bai;
          score_d   = score_q + SCORE_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    running_d = (state_d == ST_RUN);
    sat_d     = (score_d == MAX_BIN);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pass_q     <= 1'b0;
      cur_ge_q   <= '0;
      cur_shi_q  <= '0;
      cur_bai_q  <= '0;
      score_q    <= '0;
      best_ge_q  <= '0;
      best_shi_q <= '0;
      best_bai_q <= '0;
      best_q     <= '0;
      running_q  <= 1'b0;
      sat_q      <= 1'b0;
      new_best_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_q     <= pass;
      cur_ge_q   <= cur_ge_d;
      cur_shi_q  <= cur_shi_d;
      cur_bai_q  <= cur_bai_d;
      score_q    <= score_d;
      best_ge_q  <= best_ge_d;
      best_shi_q <= best_shi_d;
      best_bai_q <= best_bai_d;
      best_q     <= best_d;
      running_q  <= running_d;
      sat_q      <= sat_d;
      new_best_q <= new_best_d;
    end
  end

  // Display select is a plain mux off registers so show_best acts immediately
  assign ge  = show_best ? best_ge_q  : cur_ge_q;
  assign shi = show_best ? best_shi_q : cur_shi_q;
  assign bai = show_best ? best_bai_q : cur_bai_q;

  assign score_bin = score_q;
  assign best_bin  = best_q;
  assign running   = running_q;
  assign saturated = sat_q;
  assign new_best  = new_best_q;

endmodule

// File: tb/tb_score_bcd_counter.sv
// Bench for score_bcd_counter: default instance plus a MAX_SCORE=15 instance
// driven by the same inputs, checked against a binary reference model.
module tb_score_bcd_counter;

  logic clk = 1'b0;
  logic rst, pass, game_start, game_over, show_best;

  logic [3:0] ge0, shi0, bai0, ge1, shi1, bai1;
  logic [9:0] sc0, bs0, sc1, bs1;
  logic       run0, sat0, nb0, run1, sat1, nb1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [9:0]  sc;
    logic [9:0]  bs;
    logic        run;
    logic        sat;
    logic        nb;
    logic [11:0] dig;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: binary scores per instance
  int m_st;
  int m_pq;
  int m_sc[2];
  int m_bs[2];
  int m_nb[2];
  int m_max[2] = '{999, 15};

  score_bcd_counter dut (
    .clk(clk), .rst(rst), .pass(pass), .game_start(game_start),
    .game_over(game_over), .show_best(show_best),
    .ge(ge0), .shi(shi0), .bai(bai0), .score_bin(sc0), .best_bin(bs0),
    .running(run0), .saturated(sat0), .new_best(nb0)
  );

  score_bcd_counter #(.MAX_SCORE(15)) dut15 (
    .clk(clk), .rst(rst), .pass(pass), .game_start(game_start),
    .game_over(game_over), .show_best(show_best),
    .ge(ge1), .shi(shi1), .bai(bai1), .score_bin(sc1), .best_bin(bs1),
    .running(run1), .saturated(sat1), .new_best(nb1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model using the inputs about to be sampled and queue the expectation
  task automatic model_step();
    int edge_seen;
    int st;
    edge_seen = (pass && !m_pq) ? 1 : 0;
    st = m_st;
    for (int k = 0; k < 2; k++) begin
      m_nb[k] = 0;
      if (rst) begin
        m_sc[k] = 0;
        m_bs[k] = 0;
      end else if (m_st == 1) begin
        if (game_start) m_sc[k] = 0;
        else if (game_over) begin
          if (m_sc[k] > m_bs[k]) begin
            m_bs[k] = m_sc[k];
            m_nb[k] = 1;
          end
        end else if (edge_seen == 1 && m_sc[k] < m_max[k]) m_sc[k]++;
      end else if (game_start) m_sc[k] = 0;
    end
    if (rst) st = 0;
    else if (game_start) st = 1;
    else if (m_st == 1 && game_over) st = 2;
    m_st = st;
    m_pq = rst ? 0 : int'(pass);
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e.sc  = 10'(m_sc[k]);
      e.bs  = 10'(m_bs[k]);
      e.run = (m_st == 1);
      e.sat = (m_sc[k] == m_max[k]);
      e.nb  = 1'(m_nb[k]);
      e.dig = to_bcd(show_best ? m_bs[k] : m_sc[k]);
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (q0.size() == 0 || q1.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = q0.pop_front();
      chk("score0", 32'(sc0), 32'(e.sc));
      chk("best0", 32'(bs0), 32'(e.bs));
      chk("running0", 32'(run0), 32'(e.run));
      chk("saturated0", 32'(sat0), 32'(e.sat));
      chk("new_best0", 32'(nb0), 32'(e.nb));
      chk("digits0", 32'({bai0, shi0, ge0}), 32'(e.dig));
      e = q1.pop_front();
      chk("score15", 32'(sc1), 32'(e.sc));
      chk("best15", 32'(bs1), 32'(e.bs));
      chk("running15", 32'(run1), 32'(e.run));
      chk("saturated15", 32'(sat1), 32'(e.sat));
      chk("new_best15", 32'(nb1), 32'(e.nb));
      chk("digits15", 32'({bai1, shi1, ge1}), 32'(e.dig));
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      pass = 1'b1; tick();
      pass = 1'b0; tick();
    end
  endtask

  task automatic start_game();
    game_start = 1'b1; tick();
    game_start = 1'b0;
  endtask

  task automatic end_game();
    game_over = 1'b1; tick();
    game_over = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pass = 1'b0; game_start = 1'b0; game_over = 1'b0; show_best = 1'b0;
    m_st = 0; m_pq = 0;
    for (int k = 0; k < 2; k++) begin m_sc[k] = 0; m_bs[k] = 0; m_nb[k] = 0; end
    @(negedge clk);

    // Reset and idle behaviour
    tick(); tick();
    chk("reset_digits", 32'({bai0, shi0, ge0}), 32'h000);
    rst = 1'b0;
    pulses(3);
    chk("idle_score", 32'(sc0), 32'd0);

    // Counting and BCD carries
    start_game();
    chk("start_running", 32'(run0), 32'd1);
    pulses(109);
    chk("count109_bin", 32'(sc0), 32'd109);
    chk("count109_dig", 32'({bai0, shi0, ge0}), 32'h109);
    pulses(1);
    chk("count110_dig", 32'({bai0, shi0, ge0}), 32'h110);
    chk("sat15_bin", 32'(sc1), 32'd15);
    chk("sat15_dig", 32'({bai1, shi1, ge1}), 32'h015);
    chk("sat15_flag", 32'(sat1), 32'd1);

    // Held level counts once
    pass = 1'b1;
    repeat (20) tick();
    pass = 1'b0; tick();
    chk("held_level", 32'(sc0), 32'd111);

    // start and over together: restart wins, no best commit
    game_start = 1'b1; game_over = 1'b1; tick();
    game_start = 1'b0; game_over = 1'b0;
    chk("start_over_score", 32'(sc0), 32'd0);
    chk("start_over_nb", 32'(nb0), 32'd0);
    chk("start_over_run", 32'(run0), 32'd1);

    // Pass edge coincident with over is dropped
    pulses(5);
    pass = 1'b1; game_over = 1'b1; tick();
    pass = 1'b0; game_over = 1'b0;
    chk("edge_with_over", 32'(sc0), 32'd5);
    chk("over_state", 32'(run0), 32'd0);
    pulses(2);
    chk("over_ignores_pass", 32'(sc0), 32'd5);

    // Best tracking from a clean reset
    rst = 1'b1; tick(); rst = 1'b0;
    start_game(); pulses(12); end_game();
    chk("game1_best", 32'(bs0), 32'd12);
    chk("game1_nb", 32'(nb0), 32'd1);
    tick();
    chk("game1_nb_drop", 32'(nb0), 32'd0);
    start_game(); pulses(12); end_game();
    chk("game2_nb", 32'(nb0), 32'd0);
    start_game(); pulses(7); end_game();
    chk("game3_best", 32'(bs0), 32'd12);
    show_best = 1'b1; #1;
    chk("show_best_dig", 32'({bai0, shi0, ge0}), 32'h012);
    show_best = 1'b0; #1;
    chk("show_cur_dig", 32'({bai0, shi0, ge0}), 32'h007);

    // Default saturation at 999
    start_game(); pulses(1000);
    chk("sat999_dig", 32'({bai0, shi0, ge0}), 32'h999);
    chk("sat999_flag", 32'(sat0), 32'd1);

    // Reset in the middle of a game with a best on record
    rst = 1'b1; tick(); rst = 1'b0;
    start_game(); pulses(30); end_game();
    start_game(); pulses(40);
    chk("pre_reset_score", 32'(sc0), 32'd40);
    rst = 1'b1; pass = 1'b1; game_start = 1'b1; tick();
    rst = 1'b0; pass = 1'b0; game_start = 1'b0;
    chk("mid_reset_best", 32'(bs0), 32'd0);
    chk("mid_reset_run", 32'(run0), 32'd0);
    start_game(); pulses(1);
    chk("post_reset_score", 32'(sc0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
